// File: rtl/mode_pkg.sv
// Shared types and constants for the watch mode controller.
package mode_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'd0,
        MODE_SW    = 2'd1,
        MODE_TIMER = 2'd2
    } mode_e;

    localparam int unsigned NUM_BTN   = 5;
    localparam int unsigned BTN_MODE  = 0;
    localparam int unsigned BTN_INC   = 1;
    localparam int unsigned BTN_DEC   = 2;
    localparam int unsigned BTN_STATE = 3;
    localparam int unsigned BTN_START = 4;

    localparam int unsigned HOUR_W = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MS_W   = 7;

    typedef struct packed {
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
        logic [SEC_W-1:0]  seconds;
        logic [MS_W-1:0]   milliseconds;
    } time_t;

    // Command-routing mask: bit index equals the mode index.
    function automatic logic [2:0] mode_onehot(input mode_e m);
        logic [2:0] mask;
        mask = 3'b000;
        case (m)
            MODE_CLOCK: mask = 3'b001;
            MODE_SW:    mask = 3'b010;
            MODE_TIMER: mask = 3'b100;
            default:    mask = 3'b000;
        endcase
        return mask;
    endfunction

    function automatic mode_e next_mode(input mode_e m);
        mode_e n;
        n = MODE_CLOCK;
        case (m)
            MODE_CLOCK: n = MODE_SW;
            MODE_SW:    n = MODE_TIMER;
            default:    n = MODE_CLOCK;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer plus rising-edge detector for one raw button level.
module btn_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse_c
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] fill;

    // fill gates the detector until prev holds a real sample, so a button
    // already held through reset cannot fake a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            fill  <= 2'd0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            prev  <= sync2;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign pulse_c = sync2 & ~prev & (fill == 2'd3);

endmodule

// File: rtl/mode_controller.sv
// Mode selection, command routing, display mux and timer-expiry alarm for the watch.
module mode_controller
    import mode_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  btn,
    input  time_t       clock_time,
    input  time_t       sw_time,
    input  time_t       timer_time,
    input  logic        timer_done,
    output logic [1:0]  sel,
    output logic [2:0]  inc_o,
    output logic [2:0]  dec_o,
    output logic [2:0]  state_o,
    output logic [2:0]  start_o,
    output logic [5:0]  hours,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic [6:0]  milliseconds,
    output logic        alarm,
    output logic        alarm_led
);

    localparam int unsigned CNT_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [NUM_BTN-1:0] pulse_c;
    mode_e              mode_q;
    logic               td_prev;
    logic [CNT_W-1:0]   blink_cnt;
    logic               td_rise_c;
    logic [2:0]         cmd_mask_c;
    time_t              disp_c;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_sync u_btn_sync (
            .clk     (clk),
            .reset   (reset),
            .btn     (btn[i]),
            .pulse_c (pulse_c[i])
        );
    end

    assign td_rise_c  = timer_done & ~td_prev;
    assign cmd_mask_c = mode_onehot(mode_q);
    assign sel        = 2'(mode_q);

    always_comb begin
        disp_c = clock_time;
        case (mode_q)
            MODE_SW:    disp_c = sw_time;
            MODE_TIMER: disp_c = timer_time;
            default:    disp_c = clock_time;
        endcase
    end

    // Priority: timer expiry, then alarm acknowledge, then mode change, then commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q       <= MODE_CLOCK;
            td_prev      <= 1'b0;
            inc_o        <= 3'b000;
            dec_o        <= 3'b000;
            state_o      <= 3'b000;
            start_o      <= 3'b000;
            hours        <= '0;
            minutes      <= '0;
            seconds      <= '0;
            milliseconds <= '0;
            alarm        <= 1'b0;
            alarm_led    <= 1'b0;
            blink_cnt    <= '0;
        end else begin
            td_prev      <= timer_done;
            hours        <= disp_c.hours;
            minutes      <= disp_c.minutes;
            seconds      <= disp_c.seconds;
            milliseconds <= disp_c.milliseconds;
            inc_o        <= 3'b000;
            dec_o        <= 3'b000;
            state_o      <= 3'b000;
            start_o      <= 3'b000;

            if (td_rise_c) begin
                alarm     <= 1'b1;
                alarm_led <= 1'b1;
                blink_cnt <= '0;
                mode_q    <= MODE_TIMER;
            end else if (alarm) begin
                if (|pulse_c) begin
                    alarm     <= 1'b0;
                    alarm_led <= 1'b0;
                    blink_cnt <= '0;
                end else if (blink_cnt == CNT_LAST) begin
                    blink_cnt <= '0;
                    alarm_led <= ~alarm_led;
                end else begin
                    blink_cnt <= blink_cnt + CNT_W'(1);
                end
            end else if (pulse_c[BTN_MODE]) begin
                mode_q <= next_mode(mode_q);
            end else begin
                inc_o   <= pulse_c[BTN_INC]   ? cmd_mask_c : 3'b000;
                dec_o   <= pulse_c[BTN_DEC]   ? cmd_mask_c : 3'b000;
                state_o <= pulse_c[BTN_STATE] ? cmd_mask_c : 3'b000;
                start_o <= pulse_c[BTN_START] ? cmd_mask_c : 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_mode_controller.sv
// Self-checking bench for mode_controller: directed table, corner sequences, random vs model.
module tb_mode_controller;
    import mode_pkg::*;

    localparam int BLINK = 50;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btn;
    time_t       clock_time, sw_time, timer_time;
    logic        timer_done;
    logic [1:0]  sel;
    logic [2:0]  inc_o, dec_o, state_o, start_o;
    logic [5:0]  hours, minutes, seconds;
    logic [6:0]  milliseconds;
    logic        alarm, alarm_led;

    mode_controller #(.BLINK_CYCLES(BLINK)) dut (
        .clk(clk), .reset(reset), .btn(btn),
        .clock_time(clock_time), .sw_time(sw_time), .timer_time(timer_time),
        .timer_done(timer_done), .sel(sel),
        .inc_o(inc_o), .dec_o(dec_o), .state_o(state_o), .start_o(start_o),
        .hours(hours), .minutes(minutes), .seconds(seconds), .milliseconds(milliseconds),
        .alarm(alarm), .alarm_led(alarm_led)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: the sampled button stream since reset and the watch's visible behaviour.
    int unsigned n_edges;
    logic [4:0]  h1, h2, h3;
    int          sel_m;
    bit          alarm_m;
    int          age_m;
    bit          td_prev_m;
    logic [2:0]  cmd_m [5];
    logic [24:0] disp_m;

    // Accumulators for directed checks.
    logic [2:0]  acc_inc, acc_dec, acc_state, acc_start;
    int          acc_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_edges = 0;
        h1 = '0; h2 = '0; h3 = '0;
        sel_m = 0; alarm_m = 0; age_m = 0; td_prev_m = 0;
        for (int k = 0; k < 5; k++) cmd_m[k] = 3'b000;
        disp_m = '0;
    endtask

    task automatic model_step(input logic r, input logic [4:0] b, input logic td,
                              input time_t t0, input time_t t1, input time_t t2);
        logic [4:0] p;
        bit rise;
        if (!r) begin
            model_reset();
            return;
        end
        n_edges++;
        // A pulse is a low-then-high pair in the sampled stream, both samples taken after reset.
        p = (n_edges >= 4) ? (h2 & ~h3) : 5'b0;
        h3 = h2; h2 = h1; h1 = b;
        rise = td && !td_prev_m;
        td_prev_m = td;
        disp_m = (sel_m == 0) ? t0 : (sel_m == 1) ? t1 : t2;
        for (int k = 0; k < 5; k++) cmd_m[k] = 3'b000;
        if (rise) begin
            alarm_m = 1; sel_m = 2; age_m = 0;
        end else if (alarm_m) begin
            if (p != 0) alarm_m = 0;
            else age_m++;
        end else if (p[0]) begin
            sel_m = (sel_m + 1) % 3;
        end else begin
            for (int k = 1; k < 5; k++) if (p[k]) cmd_m[k] = 3'(1 << sel_m);
        end
    endtask

    task automatic compare_model();
        bit led_m;
        led_m = alarm_m && (((age_m / BLINK) % 2) == 0);
        check("model_sel", 32'(sel), 32'(sel_m));
        check("model_alarm", 32'(alarm), 32'(alarm_m));
        check("model_led", 32'(alarm_led), 32'(led_m));
        check("model_cmd", 32'({start_o, state_o, dec_o, inc_o}),
              32'({cmd_m[4], cmd_m[3], cmd_m[2], cmd_m[1]}));
        check("model_disp", 32'({hours, minutes, seconds, milliseconds}), 32'(disp_m));
    endtask

    task automatic clear_acc();
        acc_inc = 0; acc_dec = 0; acc_state = 0; acc_start = 0; acc_cyc = 0;
    endtask

    task automatic tick();
        logic [4:0] b; logic td; logic r; time_t t0, t1, t2;
        b = btn; td = timer_done; r = reset;
        t0 = clock_time; t1 = sw_time; t2 = timer_time;
        @(posedge clk);
        model_step(r, b, td, t0, t1, t2);
        #1;
        compare_model();
        acc_inc |= inc_o; acc_dec |= dec_o; acc_state |= state_o; acc_start |= start_o;
        if ((inc_o | dec_o | state_o | start_o) != 3'b000) acc_cyc++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_alarm"}, 32'({alarm, alarm_led}), 32'd0);
        check({tag, "_cmd"}, 32'({start_o, state_o, dec_o, inc_o}), 32'd0);
        check({tag, "_disp"}, 32'({hours, minutes, seconds, milliseconds}), 32'd0);
    endtask

    typedef struct {
        logic [4:0] btn;
        int         hold;
        logic [1:0] sel;
        logic [2:0] inc, dec, state, start;
        int         cyc;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{5'b00001,  2, 2'd1, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[1]  = '{5'b00001,  2, 2'd2, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[2]  = '{5'b00001,  2, 2'd0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[3]  = '{5'b00001,  2, 2'd1, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[4]  = '{5'b00001,  2, 2'd2, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[5]  = '{5'b00010, 10, 2'd2, 3'b100, 3'b000, 3'b000, 3'b000, 1};
        vecs[6]  = '{5'b00100,  3, 2'd2, 3'b000, 3'b100, 3'b000, 3'b000, 1};
        vecs[7]  = '{5'b00001,  2, 2'd0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[8]  = '{5'b11000,  2, 2'd0, 3'b000, 3'b000, 3'b001, 3'b001, 1};
        vecs[9]  = '{5'b00001,  2, 2'd1, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[10] = '{5'b10001,  2, 2'd2, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[11] = '{5'b00001,  2, 2'd0, 3'b000, 3'b000, 3'b000, 3'b000, 0};
        vecs[12] = '{5'b00010,  2, 2'd0, 3'b001, 3'b000, 3'b000, 3'b000, 1};

        reset = 1'b0; btn = '0; timer_done = 1'b0;
        clock_time = '0; sw_time = '0; timer_time = '0;
        model_reset();
        clear_acc();
        repeat (2) tick();
        check_zero("reset");
        reset = 1'b1;
        repeat (5) tick();

        // Directed button table.
        foreach (vecs[i]) begin
            clear_acc();
            btn = vecs[i].btn;
            repeat (vecs[i].hold) tick();
            btn = '0;
            repeat (5) tick();
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            check($sformatf("vec%0d_cmd", i), 32'({acc_start, acc_state, acc_dec, acc_inc}),
                  32'({vecs[i].start, vecs[i].state, vecs[i].dec, vecs[i].inc}));
            check($sformatf("vec%0d_cyc", i), 32'(acc_cyc), 32'(vecs[i].cyc));
        end

        // Timer expiry alarm, blink, acknowledge and level-held timer_done.
        timer_done = 1'b1;
        tick();
        check("alarm_set_sel", 32'(sel), 32'd2);
        check("alarm_set", 32'({alarm, alarm_led}), 32'b11);
        repeat (49) tick();
        check("led_49", 32'(alarm_led), 32'd1);
        tick();
        check("led_50", 32'(alarm_led), 32'd0);
        repeat (50) tick();
        check("led_100", 32'(alarm_led), 32'd1);
        clear_acc();
        btn = 5'b01000;
        repeat (2) tick();
        btn = '0;
        repeat (4) tick();
        check("ack_alarm", 32'({alarm, alarm_led}), 32'd0);
        check("ack_state_o", 32'(acc_state), 32'd0);
        check("ack_cyc", 32'(acc_cyc), 32'd0);
        check("ack_sel", 32'(sel), 32'd2);
        repeat (10) tick();
        check("td_held_no_rearm", 32'(alarm), 32'd0);
        timer_done = 1'b0;
        tick();
        timer_done = 1'b1;
        tick();
        check("td_new_rise", 32'(alarm), 32'd1);
        clear_acc();
        btn = 5'b00010;
        repeat (2) tick();
        btn = '0;
        repeat (4) tick();
        check("ack2_alarm", 32'(alarm), 32'd0);
        check("ack2_inc", 32'(acc_inc), 32'd0);
        timer_done = 1'b0;
        tick();

        // Display of the timer, then asynchronous reset mid-run.
        timer_time = time_t'{6'd1, 6'd2, 6'd3, 7'd45};
        tick();
        check("disp_hours", 32'(hours), 32'd1);
        check("disp_minutes", 32'(minutes), 32'd2);
        check("disp_seconds", 32'(seconds), 32'd3);
        check("disp_ms", 32'(milliseconds), 32'd45);
        reset = 1'b0;
        #1;
        check_zero("async_reset");

        // Reset released while a button is held must not produce a pulse.
        btn = 5'b00001;
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) tick();
        check("held_through_reset", 32'(sel), 32'd0);
        btn = '0;
        repeat (3) tick();
        btn = 5'b00001;
        repeat (2) tick();
        btn = '0;
        repeat (4) tick();
        check("press_after_release", 32'(sel), 32'd1);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 5; k++)
                if ($urandom_range(0, 5) == 0) btn[k] = ~btn[k];
            if ($urandom_range(0, 59) == 0) timer_done = ~timer_done;
            if ($urandom_range(0, 3) == 0) clock_time = time_t'(25'($urandom));
            if ($urandom_range(0, 3) == 0) sw_time    = time_t'(25'($urandom));
            if ($urandom_range(0, 3) == 0) timer_time = time_t'(25'($urandom));
            if (i == 1500) begin
                reset = 1'b0;
                #1;
                check_zero("rand_reset");
                repeat (2) tick();
                reset = 1'b1;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 SHALL have parameter BLINK_CYCLES, default 50, meaning clk cycles per alarm_led toggle.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port btn  input  5  raw button levels {start,state,dec,inc,mode}, asynchronous to clk.
REQ-005 SHALL have ports clock_time, sw_time, timer_time  input  25 each  {hours[5:0],minutes[5:0],seconds[5:0],milliseconds[6:0]} from clock, stopwatch, timer.
REQ-006 SHALL have port timer_done  input  1  level from timer, high while expired.
REQ-007 SHALL have port sel  output  2  active mode: 0 clock, 1 stopwatch, 2 timer; 3 never driven.
REQ-008 SHALL have ports inc_o, dec_o, state_o, start_o  output  3 each  one-hot per module (bit = mode index) single-cycle command pulses.
REQ-009 SHALL have ports hours, minutes, seconds  output  6 each, milliseconds  output  7  displayed time.
REQ-010 SHALL have ports alarm  output  1  expiry latched; alarm_led  output  1  blinking indicator.

Function
REQ-011 Each btn bit SHALL pass a 2-flop synchronizer then rising-edge detect: one internal pulse, 1 cycle wide, on the 3rd rising clk edge after btn first sampled high; held level gives no further pulses.
REQ-012 Mode pulse with alarm=0 SHALL advance sel 0->1->2->0 on the same edge; sel never reaches 3.
REQ-013 Inc/dec/state/start pulses with alarm=0 SHALL appear on bit sel of the matching output, one cycle after the internal pulse; other bits 0.
REQ-014 Mode pulse coincident with any other pulse: mode wins, others dropped that cycle.
REQ-015 Multiple non-mode pulses in one cycle SHALL all be forwarded together.
REQ-016 Command outputs SHALL use sel value before any same-edge update.
REQ-017 Display outputs SHALL be registered mux of time input selected by sel: 1-cycle latency after sel or input change.
REQ-018 Rising edge of timer_done (registered compare, previous=0, current=1) SHALL set alarm=1 and force sel=2 on that edge, overriding a coincident mode pulse.
REQ-019 While alarm=1, all button pulses SHALL be consumed (no output pulse); first pulse of any button SHALL clear alarm on that edge.
REQ-020 timer_done staying high after alarm clear SHALL NOT re-set alarm; a new 0->1 transition is required.
REQ-021 alarm_led SHALL be 0 when alarm=0; on alarm set, alarm_led=1 and toggles every BLINK_CYCLES cycles via counter 0..BLINK_CYCLES-1 wrapping; counter cleared when alarm clears.

Reset
REQ-022 reset low SHALL asynchronously force: sel=0, all command outputs 0, hours/minutes/seconds/milliseconds 0, alarm 0, alarm_led 0, synchronizers, edge registers, blink counter 0.
REQ-023 Reset released mid-press SHALL NOT yield a pulse until btn is seen low then high again.

Structure
REQ-024 Package mode_pkg SHALL hold mode_e enum (MODE_CLOCK=0, MODE_SW=1, MODE_TIMER=2), button index constants (BTN_MODE..BTN_START), time_t packed 25-bit struct.
REQ-025 Synchronizer plus edge detect SHALL be sub-module btn_sync (1-bit, instantiated 5x); rest in mode_controller.

Verification
REQ-026 Reset, press mode 4 times -> sel 1,2,0,1; no command pulses.
REQ-027 sel=2, press inc held 10 cycles -> inc_o=3'b100 exactly 1 cycle; held level no repeat.
REQ-028 sel=1, mode and start same cycle -> sel=2, start_o stays 0.
REQ-029 sel=0, timer_done 0->1 -> sel=2, alarm=1, alarm_led toggles every 50 cycles; press state -> alarm=0, alarm_led=0, state_o 0; timer_done still high -> alarm stays 0.
REQ-030 sel=2, timer_time=1:02:03.45 -> hours=1, minutes=2, seconds=3, milliseconds=45 one cycle later; assert reset mid-run -> all outputs 0 immediately.
